// File: rtl/input_capture_pkg.sv
// Shared types, reset constants and sizing helper for the input_capture front end.
// Debouncers are compiled in only when INPUT_CAPTURE_DEBOUNCE_EN is defined.
package input_capture_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cap_state_e;

  localparam logic       RST_BIT     = 1'b0;
  localparam logic       RST_VALID   = 1'b0;
  localparam logic       RST_OVERRUN = 1'b0;
  localparam cap_state_e RST_STATE   = ST_EMPTY;

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int unsigned dbc_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 32'd1);
  endfunction

endpackage

// File: rtl/input_capture_btn_debounce.sv
// Single-button debouncer: the stable level flips only after DEBOUNCE_CYCLES
// consecutive samples disagree with it.
module btn_debounce
  import input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic In,
  output logic Out
);

  localparam int unsigned      CNT_W    = dbc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the run of disagreeing ones.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = CNT_ZERO;
    if (In == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stable_q <= RST_BIT;
      cnt_q    <= CNT_ZERO;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Out = stable_q;

endmodule

// File: rtl/input_capture.sv
// Board front end: synchronises switches/buttons, debounces buttons when
// INPUT_CAPTURE_DEBOUNCE_EN is defined, and hands captured operands over valid/ready.
module input_capture
  import input_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [2*WIDTH-1:0] Sw,
  input  logic               Btn0,
  input  logic               Btn1,
  output logic [WIDTH-1:0]   InputX,
  output logic [WIDTH-1:0]   InputY,
  output logic               Cin,
  output logic               Valid,
  input  logic               Ready,
  output logic               Overrun
);

  localparam int unsigned      NBITS   = 2 * WIDTH + 2;
  localparam logic [WIDTH-1:0] OP_ZERO = {WIDTH{RST_BIT}};

  logic [NBITS-1:0] sync_q [SYNC_STAGES];
  logic [NBITS-1:0] sync_d [SYNC_STAGES];
  logic [NBITS-1:0] synced;
  logic [2*WIDTH-1:0] sw_sync;
  logic               btn0_sync, btn1_sync;
  logic               btn0_stable, btn1_stable;
  logic               btn1_prev_q;
  logic               load_event;

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // All pins share one synchroniser chain; stage 0 samples the raw pins.
  always_comb begin
    sync_d[0] = {Btn1, Btn0, Sw};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {NBITS{RST_BIT}};
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign synced    = sync_q[SYNC_STAGES-1];
  assign sw_sync   = synced[2*WIDTH-1:0];
  assign btn0_sync = synced[2*WIDTH];
  assign btn1_sync = synced[2*WIDTH+1];

`ifdef INPUT_CAPTURE_DEBOUNCE_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn0 (
    .Clk (Clk),
    .Rst (Rst),
    .In  (btn0_sync),
    .Out (btn0_stable)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn1 (
    .Clk (Clk),
    .Rst (Rst),
    .In  (btn1_sync),
    .Out (btn1_stable)
  );
`else
  assign btn0_stable = btn0_sync;
  assign btn1_stable = btn1_sync;
`endif

  // Registered copy of the load button; only its rising edge loads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      btn1_prev_q <= RST_BIT;
    end else begin
      btn1_prev_q <= btn1_stable;
    end
  end

  assign load_event = btn1_stable & ~btn1_prev_q;

  // Capture/handshake next state; a load while stalled is dropped and flagged.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_EMPTY: begin
        if (load_event) begin
          x_d     = sw_sync[WIDTH-1:0];
          y_d     = sw_sync[2*WIDTH-1:WIDTH];
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (Ready) begin
          if (load_event) begin
            x_d     = sw_sync[WIDTH-1:0];
            y_d     = sw_sync[2*WIDTH-1:WIDTH];
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          if (load_event) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
    valid_d = (state_d == ST_FULL);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= RST_STATE;
      x_q       <= OP_ZERO;
      y_q       <= OP_ZERO;
      valid_q   <= RST_VALID;
      overrun_q <= RST_OVERRUN;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign InputX  = x_q;
  assign InputY  = y_q;
  assign Cin     = btn0_stable;
  assign Valid   = valid_q;
  assign Overrun = overrun_q;

endmodule
